// File: rtl/mips32_boot_ctrl.sv
// Boot/run sequencer for the mips32 core: streams a program into the core's
// unified memory, holds the core in reset while loading, then releases it and
// runs it until it halts or its cycle budget expires.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for the first program word (ld_ready high)
// LOAD    | accepting program words into memory
// ARMED   | program loaded, core held in reset, waiting for start
// RESET   | core reset held for RESET_HOLD cycles before running
// RUN     | core running, cycle budget counting
// DONE    | core raised halted; cycle_count frozen
// TIMEOUT | cycle budget exhausted without halt; cycle_count frozen
module mips32_boot_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned RESET_HOLD = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              start,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              core_run,
  input  logic              halted,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_ovf,
  output logic [ADDR_W:0]   word_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_RESET   = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_TIMEOUT = 3'd6;

  // Pointer is one bit wider than the address so a full memory is detectable
  // without ever wrapping the address.
  localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  PTR_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

  localparam int unsigned      HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              err_ovf_q, err_ovf_d;
  logic              accept;

  assign ld_ready    = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept      = ld_valid && ld_ready;
  assign core_rst_n  = (state_q == S_RUN) || (state_q == S_DONE) || (state_q == S_TIMEOUT);
  assign core_run    = (state_q == S_RUN);
  assign busy        = (state_q == S_LOAD) || (state_q == S_RESET) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign err_timeout = (state_q == S_TIMEOUT);
  assign err_ovf     = err_ovf_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign word_count  = word_count_q;
  assign cycle_count = cycle_count_q;

  // Next-state and datapath update; clear overrides every other input.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    word_count_d  = word_count_q;
    cycle_count_d = cycle_count_q;
    hold_d        = hold_q;
    err_ovf_d     = err_ovf_q;

    if (clear) begin
      state_d   = S_IDLE;
      err_ovf_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = '0;
            mem_wdata_d = ld_data;
            wr_ptr_d    = PTR_ONE;
            if (ld_last) begin
              word_count_d = PTR_ONE;
              state_d      = S_ARMED;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (wr_ptr_q == PTR_FULL) begin
              // Memory already full: drop the word rather than wrap.
              err_ovf_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = wr_ptr_q[ADDR_W-1:0];
              mem_wdata_d = ld_data;
              wr_ptr_d    = wr_ptr_q + PTR_ONE;
              if (ld_last) begin
                word_count_d = wr_ptr_q + PTR_ONE;
                state_d      = S_ARMED;
              end
            end
          end
        end
        S_ARMED, S_DONE, S_TIMEOUT: begin
          if (start) begin
            cycle_count_d = '0;
            hold_d        = HOLD_INIT;
            state_d       = S_RESET;
          end
        end
        S_RESET: begin
          if (hold_q == '0) begin
            cycle_count_d = CNT_ONE;
            state_d       = S_RUN;
          end else begin
            hold_d = hold_q - HOLD_ONE;
          end
        end
        S_RUN: begin
          if (halted) begin
            state_d = S_DONE;
          end else if (cycle_count_q == CNT_MAX) begin
            state_d = S_TIMEOUT;
          end else begin
            cycle_count_d = cycle_count_q + CNT_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      word_count_q  <= '0;
      cycle_count_q <= '0;
      hold_q        <= '0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      word_count_q  <= word_count_d;
      cycle_count_q <= cycle_count_d;
      hold_q        <= hold_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_mips32_boot_ctrl.sv
// Bench for mips32_boot_ctrl: a small core model drives halted, a behavioural
// reference predicts every output each cycle, and directed scenarios add
// literal expectations at key points.
module tb_mips32_boot_ctrl;

  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;
  localparam int MAXC   = 20;
  localparam int HOLD   = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              ld_valid, ld_ready, ld_last, start, clear;
  logic [31:0]       ld_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst_n, core_run, halted, busy, done, err_timeout, err_ovf;
  logic [ADDR_W:0]   word_count;
  logic [CNT_W-1:0]  cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  mips32_boot_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_CYCLES(MAXC), .RESET_HOLD(HOLD)) dut (
    .clk1(clk1), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .start(start), .clear(clear), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst_n(core_rst_n), .core_run(core_run), .halted(halted),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_ovf(err_ovf),
    .word_count(word_count), .cycle_count(cycle_count));

  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model: Halted rises once the core has run halt_at enabled cycles.
  int halt_at = 0;
  int run_seen = 0;
  initial halted = 1'b0;
  always @(negedge clk1) begin
    if (!core_rst_n) run_seen = 0;
    else if (core_run) run_seen++;
    halted = (halt_at != 0) && (run_seen >= halt_at);
  end

  // Reference model, phrased as modes plus counters.
  typedef enum int {M_IDLE, M_LOAD, M_ARMED, M_RESET, M_RUN, M_DONE, M_TIMEOUT} mode_t;
  mode_t       m_mode;
  int          m_ptr, m_words, m_cnt, m_held;
  bit          m_ovf, m_we;
  int          m_addr;
  logic [31:0] m_data;

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_ptr = 0; m_words = 0; m_cnt = 0; m_held = 0;
      m_ovf = 0; m_we = 0; m_addr = 0; m_data = '0;
    end else begin
      m_we = 0;
      if (clear) begin
        m_mode = M_IDLE;
        m_ovf  = 0;
      end else if (ld_valid && (m_mode == M_IDLE || m_mode == M_LOAD)) begin
        if (m_mode == M_IDLE) m_ptr = 0;
        if (m_ptr == DEPTH) begin
          m_ovf  = 1;
          m_mode = M_IDLE;
        end else begin
          m_we = 1; m_addr = m_ptr; m_data = ld_data; m_ptr++;
          if (ld_last) begin m_words = m_ptr; m_mode = M_ARMED; end
          else m_mode = M_LOAD;
        end
      end else if (start && (m_mode == M_ARMED || m_mode == M_DONE || m_mode == M_TIMEOUT)) begin
        m_mode = M_RESET; m_cnt = 0; m_held = 0;
      end else if (m_mode == M_RESET) begin
        m_held++;
        if (m_held == HOLD) begin m_mode = M_RUN; m_cnt = 1; end
      end else if (m_mode == M_RUN) begin
        if (halted) m_mode = M_DONE;
        else if (m_cnt == MAXC) m_mode = M_TIMEOUT;
        else m_cnt++;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of memory writes.
  int          n_writes = 0;
  int          last_waddr = -1;
  logic [31:0] wr_log [0:DEPTH-1];
  always @(negedge clk1) begin
    if (rst_n) begin
      chk("ld_ready", 64'(ld_ready), 64'(m_mode == M_IDLE || m_mode == M_LOAD));
      chk("busy", 64'(busy), 64'(m_mode == M_LOAD || m_mode == M_RESET || m_mode == M_RUN));
      chk("done", 64'(done), 64'(m_mode == M_DONE));
      chk("err_timeout", 64'(err_timeout), 64'(m_mode == M_TIMEOUT));
      chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
      chk("core_rst_n", 64'(core_rst_n), 64'(m_mode == M_RUN || m_mode == M_DONE || m_mode == M_TIMEOUT));
      chk("core_run", 64'(core_run), 64'(m_mode == M_RUN));
      chk("word_count", 64'(word_count), 64'(m_words));
      chk("cycle_count", 64'(cycle_count), 64'(m_cnt));
      chk("mem_we", 64'(mem_we), 64'(m_we));
      if (m_we) begin
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(m_data));
      end
      if (mem_we === 1'b1) begin
        n_writes++;
        last_waddr = int'(mem_addr);
        wr_log[mem_addr] = mem_wdata;
      end
    end
  end

  logic [31:0] prog [0:15];

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  // Streams prog[0..n-1]; with toggle, an idle cycle carrying a start pulse
  // precedes every word.
  task automatic load_words(input int n, input bit last, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle) begin
        ld_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
      end
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = last && (i == n - 1);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    tick(); tick();
  endtask

  // Waits up to max_cyc cycles for the requested flag (0 done, 1 err_timeout).
  task automatic wait_flag(input int which, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if ((which == 0 && done) || (which == 1 && err_timeout)) break;
      tick();
    end
  endtask

  int rst_cycles;

  initial begin
    prog[0] = 32'h10010005; prog[1] = 32'h10020005; prog[2] = 32'h24e73800;
    prog[3] = 32'h24e73800; prog[4] = 32'h00221800; prog[5] = 32'hfc000000;
    for (int i = 6; i < 16; i++) prog[i] = 32'hA5000000 + 32'(i);
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; start = 1'b0; clear = 1'b0;

    #2;
    chk("rst core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst mem_we", 64'(mem_we), 64'd0);
    chk("rst cycle_count", 64'(cycle_count), 64'd0);
    chk("rst word_count", 64'(word_count), 64'd0);
    chk("rst err_ovf", 64'(err_ovf), 64'd0);
    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    tick();
    chk("post-rst ld_ready", 64'(ld_ready), 64'd1);

    // Six-word program, continuous valid.
    n_writes = 0;
    load_words(6, 1'b1, 1'b0);
    chk("load6 writes", 64'(n_writes), 64'd6);
    chk("load6 word_count", 64'(word_count), 64'd6);
    chk("load6 armed ld_ready", 64'(ld_ready), 64'd0);
    chk("load6 core_rst_n", 64'(core_rst_n), 64'd0);
    chk("load6 mem[0]", 64'(wr_log[0]), 64'h10010005);
    chk("load6 mem[5]", 64'(wr_log[5]), 64'hfc000000);

    // Run to halt after 12 cycles.
    halt_at = 12;
    pulse_start();
    rst_cycles = 0;
    while (!core_rst_n && rst_cycles < 10) begin rst_cycles++; tick(); end
    chk("reset hold cycles", 64'(rst_cycles), 64'd2);
    chk("first run cycle_count", 64'(cycle_count), 64'd1);
    chk("first run core_run", 64'(core_run), 64'd1);
    wait_flag(0, 100);
    chk("halt done", 64'(done), 64'd1);
    chk("halt cycle_count", 64'(cycle_count), 64'd12);
    chk("halt core_run", 64'(core_run), 64'd0);
    chk("halt busy", 64'(busy), 64'd0);

    // Timeout with halted never rising, then re-run.
    halt_at = 0;
    pulse_start();
    wait_flag(1, 100);
    chk("timeout flag", 64'(err_timeout), 64'd1);
    chk("timeout cycle_count", 64'(cycle_count), 64'd20);
    chk("timeout core_run", 64'(core_run), 64'd0);
    tick(); tick();
    chk("timeout count frozen", 64'(cycle_count), 64'd20);
    pulse_start();
    tick(); tick();
    chk("rerun cycle_count", 64'(cycle_count), 64'd1);
    chk("rerun err_timeout", 64'(err_timeout), 64'd0);
    wait_flag(1, 100);
    chk("rerun timeout", 64'(err_timeout), 64'd1);

    // Gappy load with start pulses that must be ignored.
    pulse_clear();
    n_writes = 0;
    for (int i = 0; i < 6; i++) prog[i] = 32'hC0DE0000 + 32'(i);
    load_words(5, 1'b1, 1'b1);
    chk("gappy writes", 64'(n_writes), 64'd5);
    chk("gappy word_count", 64'(word_count), 64'd5);
    chk("gappy last addr", 64'(last_waddr), 64'd4);
    chk("gappy mem[4]", 64'(wr_log[4]), 64'hC0DE0004);
    chk("gappy not started", 64'(busy), 64'd0);

    // Overflow: nine words into eight locations, no ld_last.
    pulse_clear();
    n_writes = 0;
    load_words(9, 1'b0, 1'b0);
    chk("ovf writes", 64'(n_writes), 64'd8);
    chk("ovf last addr", 64'(last_waddr), 64'd7);
    chk("ovf flag", 64'(err_ovf), 64'd1);
    chk("ovf idle ld_ready", 64'(ld_ready), 64'd1);
    chk("ovf idle busy", 64'(busy), 64'd0);
    chk("ovf mem[7]", 64'(wr_log[7]), 64'hA5000007);

    // Halt and budget limit in the same cycle.
    pulse_clear();
    chk("clear ovf", 64'(err_ovf), 64'd0);
    load_words(2, 1'b1, 1'b0);
    halt_at = 20;
    pulse_start();
    wait_flag(0, 100);
    chk("tie done", 64'(done), 64'd1);
    chk("tie timeout", 64'(err_timeout), 64'd0);
    chk("tie cycle_count", 64'(cycle_count), 64'd20);

    // Async reset in the middle of a run.
    halt_at = 0;
    pulse_start();
    repeat (6) tick();
    chk("pre-rst core_run", 64'(core_run), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst core_rst_n", 64'(core_rst_n), 64'd0);
    chk("midrst core_run", 64'(core_run), 64'd0);
    chk("midrst cycle_count", 64'(cycle_count), 64'd0);
    chk("midrst word_count", 64'(word_count), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst mem_addr", 64'(mem_addr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post midrst ld_ready", 64'(ld_ready), 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips32_boot_ctrl.md
Name: mips32_boot_ctrl

Overview:
Sequencing controller that sits beside the mips32 core.
- Loads a program stream into the core's unified instruction/data memory.
- Holds the core in reset during load, then releases it and runs it.
- Watches the core's Halted flag and bounds run time with a cycle budget.
- Replaces the hierarchical pokes of Mem, pc and Halted with a proper start/stop interface.

Parameters:
ADDR_W, 10, memory word-address width; memory depth is 2^ADDR_W words
CNT_W, 16, width of the run-cycle counter
MAX_CYCLES, 1000, run budget in clk1 cycles before timeout; must be < 2^CNT_W
RESET_HOLD, 2, cycles core_rst_n stays low after start before core_run rises (>=1)

Ports:
clk1 input 1 single system clock, rising edge
rst_n input 1 asynchronous active-low reset
ld_valid input 1 program word valid
ld_ready output 1 controller accepts program word
ld_data input 32 program word
ld_last input 1 marks final word of program
start input 1 single-cycle pulse: run loaded program
clear input 1 single-cycle pulse: abandon everything, return to IDLE
mem_we output 1 memory write strobe
mem_addr output ADDR_W memory word address
mem_wdata output 32 memory write data
core_rst_n output 1 active-low reset to core (clears pc, Halted, Taken_branch)
core_run output 1 core clock-enable / run permission
halted input 1 core Halted flag
busy output 1 high in LOAD, RESET, RUN
done output 1 high in DONE
err_timeout output 1 high in TIMEOUT
err_ovf output 1 sticky load-overflow flag, cleared by clear or rst_n
word_count output ADDR_W+1 number of words written by last load
cycle_count output CNT_W run cycles elapsed; frozen in DONE/TIMEOUT

Behaviour:
- Reset values (rst_n low, async):
  - state=IDLE
  - outputs low: mem_we, mem_addr, mem_wdata, core_rst_n, core_run, done, err_timeout, err_ovf, word_count, cycle_count
  - ld_ready=1 after reset release
- States: IDLE, LOAD, ARMED, RESET, RUN, DONE, TIMEOUT. clear from any state -> IDLE next cycle. clear has priority over all other inputs.
- ld_ready=1 only in IDLE and LOAD. Word accepted when ld_valid&&ld_ready.
- Write path, 1-cycle registered latency:
  - The cycle after an accept: mem_we=1, mem_addr=wr_ptr, mem_wdata=ld_data.
  - wr_ptr then increments.
  - First accept in IDLE resets wr_ptr to 0 and moves to LOAD.
- ld_last on an accepted word -> ARMED; word_count=wr_ptr+1.
  - A single-word program (ld_last on the first word) goes IDLE -> ARMED directly.
- Overflow: word 2^ADDR_W accepted without a prior ld_last is not written.
  - Sets err_ovf, goes to IDLE.
  - No address wrap ever occurs.
- core_rst_n=0 in IDLE, LOAD, ARMED and RESET; core_rst_n=1 in RUN, DONE and TIMEOUT. core_run=1 only in RUN.
- start:
  - Honoured only in ARMED, DONE or TIMEOUT -> RESET; ignored elsewhere.
  - On honouring: cycle_count, done and err_timeout are cleared; program memory is untouched (re-run allowed).
- RESET: lasts exactly RESET_HOLD cycles, then RUN.
- RUN: cycle_count increments every cycle, starting at 1 in the first RUN cycle.
  - halted=1 -> DONE.
  - Otherwise cycle_count==MAX_CYCLES -> TIMEOUT.
  - Both in the same cycle -> DONE.
- DONE and TIMEOUT: core_run=0; cycle_count holds.
- halted is ignored outside RUN.
- Reset mid-operation: immediate return to reset values. Memory contents are not guaranteed.

Test Plan:
- Load 6 words 10010005, 10020005, 24e73800, 24e73800, 00221800, fc000000 with ld_last on the 6th, ld_valid continuous.
  -> mem_we pulses at addr 0..5 with matching data, one cycle after each accept.
  -> ARMED; word_count=6; core_rst_n=0 throughout.
- From ARMED, pulse start with RESET_HOLD=2; model asserts halted 12 cycles after core_run rises.
  -> core_rst_n low for 2 cycles, then high.
  -> done=1; cycle_count=12; core_run=0; busy=0.
- MAX_CYCLES=20, halted held 0.
  -> err_timeout=1 after cycle_count reaches 20; core_run=0; start re-runs the program with cycle_count restarting at 1.
- ld_valid toggling every other cycle plus start pulses during LOAD.
  -> only valid cycles written, at contiguous addresses; start ignored.
- ADDR_W=3, 9 words with no ld_last.
  -> 8 writes (addr 0..7); err_ovf=1; state IDLE; 9th word not written.
- rst_n low mid-RUN; separately, halted and the budget limit hit together.
  -> reset: all outputs return to reset values at once, core_rst_n=0.
  -> simultaneous event: DONE, not TIMEOUT.
